// File: rtl/bcd_serial_accumulator.sv
// BCD accumulator: digit-serial add/sub of a DIGITS-digit operand into a running total.
// Ports: clk, rst (sync high), start/sub/operand in; busy, done, total, carry, invalid, hex (active-low 7-seg) out.
// Build option: define BCD_BLANK_EN to blank leading zeros on hex (digit 0 is always shown).
module bcd_serial_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   operand,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   total,
  output logic                  carry,
  output logic                  invalid,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  op_q;
  logic [W-1:0]  wk;
  logic [W-1:0]  wk_nx;
  logic          sub_q;
  logic          c;
  logic          cn;
  logic          last;
  logic          bad;
  logic [KW-1:0] k;
  logic [3:0]    o_e;
  logic [3:0]    dig;
  logic [4:0]    s;
  logic [4:0]    s_m10;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (operand[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // wk is the shadow: both operands shift right, result digits enter at the top
  always_comb begin
    o_e   = sub_q ? (4'd9 - op_q[3:0]) : op_q[3:0];
    s     = {1'b0, wk[3:0]} + {1'b0, o_e} + {4'd0, c};
    s_m10 = s - 5'd10;
    cn    = (s > 5'd9);
    dig   = cn ? s_m10[3:0] : s[3:0];
    wk_nx = (wk >> 4) | (W'(dig) << (4 * (DIGITS - 1)));
    last  = (k == KLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = bad ? S_ABORT : S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ABORT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE) || (state == S_ABORT);
  end

  // total/carry land on the edge into DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      wk      <= '0;
      sub_q   <= 1'b0;
      c       <= 1'b0;
      k       <= '0;
      total   <= '0;
      carry   <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= operand;
            sub_q   <= sub;
            c       <= sub;
            k       <= '0;
            wk      <= total;
            invalid <= bad;
          end
        end
        S_RUN: begin
          wk   <= wk_nx;
          op_q <= op_q >> 4;
          c    <= cn;
          k    <= k + 1'b1;
          if (last) begin
            total <= wk_nx;
            carry <= sub_q ? ~cn : cn;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] decode(input logic [W-1:0] v);
    logic [7*DIGITS-1:0] r;
    logic [3:0]          d;
`ifdef BCD_BLANK_EN
    logic                seen;
    seen = 1'b0;
`endif
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
`ifdef BCD_BLANK_EN
      seen = seen | (d != 4'd0) | (i == 0);
      r[7*i +: 7] = seen ? seg7(d) : 7'h7F;
`else
      r[7*i +: 7] = seg7(d);
`endif
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) hex <= decode('0);
    else     hex <= decode(total);
  end

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Directed bench for bcd_serial_accumulator at DIGITS=4, plus DIGITS=1 and 8 instances.
// Checks reset, add/sub, wrap, abort, busy-start, mid-op reset, hex decode.
module tb_bcd_serial_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] operand = '0;
  logic        busy, done, carry, invalid;
  logic [15:0] total;
  logic [27:0] hex;

  logic        st1 = 1'b0, sb1 = 1'b0;
  logic [3:0]  op1 = '0;
  logic        bz1, dn1, cy1, inv1;
  logic [3:0]  tot1;
  logic [6:0]  hx1;

  logic        st8 = 1'b0, sb8 = 1'b0;
  logic [31:0] op8 = '0;
  logic        bz8, dn8, cy8, inv8;
  logic [31:0] tot8;
  logic [55:0] hx8;

  logic        wsel1 = 1'b0;
  logic        wdone, wbusy, wcy;
  logic [31:0] wtot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_serial_accumulator #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .operand(operand),
    .busy(busy), .done(done), .total(total), .carry(carry),
    .invalid(invalid), .hex(hex)
  );

  bcd_serial_accumulator #(.DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1), .operand(op1),
    .busy(bz1), .done(dn1), .total(tot1), .carry(cy1),
    .invalid(inv1), .hex(hx1)
  );

  bcd_serial_accumulator #(.DIGITS(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8), .operand(op8),
    .busy(bz8), .done(dn8), .total(tot8), .carry(cy8),
    .invalid(inv8), .hex(hx8)
  );

  assign wdone = wsel1 ? dn1 : dn8;
  assign wbusy = wsel1 ? bz1 : bz8;
  assign wcy   = wsel1 ? cy1 : cy8;
  assign wtot  = wsel1 ? {28'd0, tot1} : tot8;

`ifdef BCD_BLANK_EN
  localparam logic [27:0] HEX_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
  localparam logic [27:0] HEX_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] o, input logic s,
                       input logic [15:0] et, input logic ec,
                       input logic ei, input int lat, input string nm);
    int  got;
    int  nb;
    bit  seen;
    got  = 0;
    nb   = 0;
    seen = 0;
    start = 1'b1; sub = s; operand = o;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) nb++;
      if (done) begin
        seen = 1;
        got  = c;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 20 cycles", nm);
    end else begin
      if (got !== lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, got, lat);
      end
      checks++;
      if (total !== et) begin
        errors++;
        $display("FAIL %s total: got %h want %h", nm, total, et);
      end
      checks++;
      if (carry !== ec) begin
        errors++;
        $display("FAIL %s carry: got %b want %b", nm, carry, ec);
      end
      checks++;
      if (invalid !== ei) begin
        errors++;
        $display("FAIL %s invalid: got %b want %b", nm, invalid, ei);
      end
      checks++;
      if (nb !== lat) begin
        errors++;
        $display("FAIL %s busy cycles: got %0d want %0d", nm, nb, lat);
      end
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle after: busy/done got %b want 00", nm, {busy, done});
    end
  endtask

  task automatic op_w(input int w, input logic [31:0] o, input logic s,
                      input logic [31:0] et, input logic ec, input string nm);
    int got;
    bit seen;
    got  = 0;
    seen = 0;
    wsel1 = (w == 1);
    if (w == 1) begin
      st1 = 1'b1; sb1 = s; op1 = o[3:0];
    end else begin
      st8 = 1'b1; sb8 = s; op8 = o;
    end
    tick();
    st1 = 1'b0; st8 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (wdone) begin
        seen = 1;
        got  = c;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || got != w + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, got, w + 1);
    end
    checks++;
    if (wtot !== et) begin
      errors++;
      $display("FAIL %s total: got %h want %h", nm, wtot, et);
    end
    checks++;
    if (wcy !== ec) begin
      errors++;
      $display("FAIL %s carry: got %b want %b", nm, wcy, ec);
    end
    tick();
    checks++;
    if (wbusy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy after: got %b want 0", nm, wbusy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({total, carry, invalid, busy, done} !== 20'd0) begin
      errors++;
      $display("FAIL reset state: got total=%h c=%b inv=%b busy=%b done=%b want 0",
               total, carry, invalid, busy, done);
    end
    checks++;
    if (hex !== HEX_ZERO) begin
      errors++;
      $display("FAIL reset hex: got %h want %h", hex, HEX_ZERO);
    end
  endtask

  task automatic test_add();
    logic [27:0] exp_hex;
    exp_hex = {7'h79, 7'h40, 7'h40, 7'h12};
    do_op(16'h0958, 1'b0, 16'h0958, 1'b0, 1'b0, 5, "add1");
    do_op(16'h0047, 1'b0, 16'h1005, 1'b0, 1'b0, 5, "add2");
    checks++;
    if (hex !== exp_hex) begin
      errors++;
      $display("FAIL add hex: got %h want %h", hex, exp_hex);
    end
  endtask

  task automatic test_wrap();
    do_op(16'h8994, 1'b0, 16'h9999, 1'b0, 1'b0, 5, "fill9999");
    do_op(16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, "add_wrap");
    checks++;
    if (hex !== HEX_ZERO) begin
      errors++;
      $display("FAIL wrap hex: got %h want %h", hex, HEX_ZERO);
    end
    do_op(16'h0001, 1'b1, 16'h9999, 1'b1, 1'b0, 5, "sub_borrow");
    do_op(16'h8999, 1'b1, 16'h1000, 1'b0, 1'b0, 5, "sub_plain");
  endtask

  task automatic test_abort();
    do_op(16'h12A4, 1'b0, 16'h1000, 1'b0, 1'b1, 1, "abort");
    do_op(16'h0005, 1'b0, 16'h1005, 1'b0, 1'b0, 5, "after_abort");
  endtask

  task automatic test_busy_start();
    int nd;
    nd = 0;
    start = 1'b1; sub = 1'b0; operand = 16'h0001;
    tick();
    start = 1'b0;
    if (done) nd++;
    tick();
    start = 1'b1; sub = 1'b1; operand = 16'h0999;
    if (done) nd++;
    tick();
    start = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      if (done) nd++;
      tick();
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL busy_start done count: got %0d want 1", nd);
    end
    checks++;
    if ({total, carry, busy} !== {16'h1006, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL busy_start result: got %h c=%b busy=%b want 1006 c=0 busy=0",
               total, carry, busy);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    nd = 0;
    start = 1'b1; sub = 1'b0; operand = 16'h0010;
    tick();
    start = 1'b0;
    if (done) nd++;
    tick();
    if (done) nd++;
    tick();
    if (done) nd++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({total, busy, done, carry} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid state: got total=%h busy=%b done=%b c=%b want 0",
               total, busy, done, carry);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) nd++;
      tick();
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL reset_mid done count: got %0d want 0", nd);
    end
  endtask

  task automatic test_widths();
    op_w(1, 32'h5, 1'b0, 32'h5, 1'b0, "d1_add5");
    op_w(1, 32'h4, 1'b0, 32'h9, 1'b0, "d1_add4");
    op_w(1, 32'h1, 1'b0, 32'h0, 1'b1, "d1_wrap");
    op_w(1, 32'h1, 1'b1, 32'h9, 1'b1, "d1_borrow");
    op_w(8, 32'h00000958, 1'b0, 32'h00000958, 1'b0, "d8_add1");
    op_w(8, 32'h00000047, 1'b0, 32'h00001005, 1'b0, "d8_add2");
    op_w(8, 32'h99998994, 1'b0, 32'h99999999, 1'b0, "d8_fill");
    op_w(8, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "d8_wrap");
    op_w(8, 32'h00000001, 1'b1, 32'h99999999, 1'b1, "d8_borrow");
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
